// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//
// Pipelined add/subtract unit built from BLOCK-bit carry-lookahead slices.
// The WIDTH-bit operation is split into STAGES = WIDTH/BLOCK slices. One slice
// is resolved per pipeline stage, and the carry between slices is registered
// between stages. Operands are captured in an input rank. Each stage then
// resolves its slice and writes the next rank, so a beat accepted at clock
// edge n is presented at the outputs after edge n+STAGES. The block accepts
// one beat per cycle.
//
// Each rank holds one packed word per beat. Its upper bits are the operand-A
// slices that are still pending. Its lower bits are the sum slices that are
// already resolved. The pending operand-B slices (already inverted for
// subtraction) travel in a separate skew vector that shrinks by BLOCK bits
// per rank.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset; clears every rank
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (0 while stalled or in reset)
//   a, b       WIDTH-bit operands
//   cin        carry-in, ignored when sub=1
//   sub        1: compute a - b
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, held while out_valid=0
//   cout       carry out of the MSB (for subtraction, 1 means no borrow)
//   ovf        signed overflow
//
// Optional build macro: PIPELINED_CLA_SAT_EN
//   When defined, the final stage saturates sum to the largest positive or
//   the most negative value whenever ovf=1. The saturation direction follows
//   the sign of operand A. When undefined, sum wraps modulo 2^WIDTH.

module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLOCK;
    // Total width of the B skew vector. Rank k carries WIDTH - k*BLOCK bits,
    // for k = 0 .. STAGES-1.
    localparam int BTOT = STAGES * WIDTH - (BLOCK * STAGES * (STAGES - 1)) / 2;

    // Rank k is the register set that feeds stage k. Rank STAGES is the output.
    wire [STAGES:0]            valid_r;
    wire [STAGES:0]            carry_r;
    wire [STAGES:0][WIDTH-1:0] x_r;
    wire [BTOT-1:0]            b_r;

    logic stall;

    // One CLA slice. Carries are expanded from generate/propagate terms, so
    // each c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0. The top carry is the
    // group carry G | P&c0. The function returns {carry_out, sum_bits}.
    function automatic logic [BLOCK:0] cla_slice(
        input logic [BLOCK-1:0] xa,
        input logic [BLOCK-1:0] xb,
        input logic             c0
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             acc;
        logic             pp;
        g    = xa & xb;
        p    = xa ^ xb;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & c0);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Every rank holds its contents while a result waits at the output.
    always_comb begin
        stall    = valid_r[STAGES] && !out_ready;
        in_ready = !reset && !stall;
    end

    // Input rank: capture the operands. Subtraction becomes a + ~b + 1.
    logic             in_valid_d, in_valid_q;
    logic             in_carry_d, in_carry_q;
    logic [WIDTH-1:0] in_a_d, in_a_q;
    logic [WIDTH-1:0] in_b_d, in_b_q;

    always_comb begin
        in_valid_d = in_valid && in_ready;
        in_a_d     = a;
        in_b_d     = sub ? ~b : b;
        in_carry_d = sub | cin;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_carry_q <= 1'b0;
            in_a_q     <= '0;
            in_b_q     <= '0;
        end else if (!stall) begin
            in_valid_q <= in_valid_d;
            // Data registers only move with a real beat, so the outputs keep
            // their last value while bubbles flow through.
            if (in_valid_d) begin
                in_carry_q <= in_carry_d;
                in_a_q     <= in_a_d;
                in_b_q     <= in_b_d;
            end
        end
    end

    assign valid_r[0]       = in_valid_q;
    assign carry_r[0]       = in_carry_q;
    assign x_r[0]           = in_a_q;
    assign b_r[WIDTH-1:0]   = in_b_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO     = gi * BLOCK;
            localparam int BW_IN  = WIDTH - gi * BLOCK;
            localparam int OFF_IN = gi * WIDTH - (BLOCK * gi * (gi - 1)) / 2;

            logic [BLOCK:0]   res;
            logic [WIDTH-1:0] x_d;
            logic [WIDTH-1:0] x_w;
            logic             carry_d;
            logic [WIDTH-1:0] x_q;
            logic             carry_q;
            logic             valid_q;

            // Resolve this slice, then overwrite the consumed A slice with
            // its sum bits.
            always_comb begin
                res             = cla_slice(x_r[gi][LO +: BLOCK], b_r[OFF_IN +: BLOCK], carry_r[gi]);
                x_d             = x_r[gi];
                x_d[LO +: BLOCK] = res[BLOCK-1:0];
                carry_d         = res[BLOCK];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    x_q     <= '0;
                end else if (!stall) begin
                    valid_q <= valid_r[gi];
                    if (valid_r[gi]) begin
                        x_q     <= x_w;
                        carry_q <= carry_d;
                    end
                end
            end

            assign valid_r[gi+1] = valid_q;
            assign carry_r[gi+1] = carry_q;
            assign x_r[gi+1]     = x_q;

            if (gi < STAGES - 1) begin : g_mid
                localparam int BW_OUT = BW_IN - BLOCK;
                logic [BW_OUT-1:0] b_d;
                logic [BW_OUT-1:0] b_q;

                // Pass the B slices that are still pending to the next rank.
                always_comb begin
                    x_w = x_d;
                    b_d = b_r[OFF_IN + BLOCK +: BW_OUT];
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        b_q <= '0;
                    end else if (!stall && valid_r[gi]) begin
                        b_q <= b_d;
                    end
                end

                assign b_r[OFF_IN + BW_IN +: BW_OUT] = b_q;
            end else begin : g_last
                logic c_msb;
                logic ovf_d;
                logic ovf_q;

                // The carry into the MSB is recovered from the MSB sum bit:
                // s = a ^ b ^ c_in, so c_in = s ^ a ^ b.
                always_comb begin
                    c_msb = x_d[WIDTH-1] ^ x_r[gi][WIDTH-1] ^ b_r[OFF_IN + BLOCK - 1];
                    ovf_d = c_msb ^ carry_d;
                    x_w   = x_d;
`ifdef PIPELINED_CLA_SAT_EN
                    // Overflow occurs only when both addends share a sign,
                    // so the sign of A gives the direction of the true result.
                    if (ovf_d) begin
                        x_w = x_r[gi][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        ovf_q <= 1'b0;
                    end else if (!stall && valid_r[gi]) begin
                        ovf_q <= ovf_d;
                    end
                end

                assign ovf = ovf_q;
            end
        end
    endgenerate

    assign out_valid = valid_r[STAGES];
    assign sum       = x_r[STAGES];
    assign cout      = carry_r[STAGES];

endmodule
